// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- elastic pipeline register with a two-entry skid buffer.
//
// Carries a W-bit payload between two pipeline stages using a valid/ready
// handshake. A main entry drives the output directly; a skid entry absorbs the
// one extra beat that can arrive while downstream stalls, so in_ready can come
// straight from a flop and still sustain one transfer per cycle.
//
// Parameters:
//   W          payload width in bits (>= 1)
//   RESET_VAL  value loaded into both data registers on reset or flush
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; overrides everything
//   flush      synchronous kill of all held entries; below reset in priority
//   in_valid   upstream offers in_data
//   in_data    upstream payload
//   in_ready   stage can accept (registered, occ != 2)
//   out_valid  main entry valid
//   out_data   main payload, straight from the register
//   out_ready  downstream accepts
//   occ        entries held: 0, 1 or 2
module pipe_skid_reg #(
  parameter int unsigned    W         = 32,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         fire_in, fire_out;

  assign fire_in  = in_valid & in_ready_q;
  assign fire_out = out_valid_q & out_ready;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;

    unique case (occ_q)
      EMPTY: begin
        if (fire_in) begin
          main_d = in_data;
          occ_d  = ONE;
        end
      end
      ONE: begin
        if (fire_in && fire_out) begin
          main_d = in_data;
        end else if (fire_in) begin
          skid_d = in_data;
          occ_d  = FULL;
        end else if (fire_out) begin
          occ_d  = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (fire_out) begin
          main_d = skid_q;
          occ_d  = ONE;
        end
      end
      default: begin
        occ_d = EMPTY;
      end
    endcase

    if (flush) begin
      occ_d  = EMPTY;
      main_d = RESET_VAL;
      skid_d = RESET_VAL;
    end

    // Valid and ready flops are precomputed from the next occupancy so that
    // every output is a plain register with no input-to-output path.
    out_valid_d = (occ_d != EMPTY);
    in_ready_d  = (occ_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      occ_q       <= occ_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed-vector and random-model bench for pipe_skid_reg.
module tb_pipe_skid_reg;

  localparam logic [31:0] RV = 32'h0BAD_F00D;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  occ;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipe_skid_reg #(.W(32), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        eov;
    logic [31:0] eod;
    logic        chkd;
    logic        eir;
    logic [1:0]  eocc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [31:0] d,
                              logic ordy, logic eov, logic [31:0] eod,
                              logic chkd, logic eir, logic [1:0] eocc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.chkd = chkd; v.eir = eir; v.eocc = eocc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] d, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  logic [31:0] model_q[$];
  logic        r_iv, r_or, m_fi, m_fo;
  logic [31:0] r_d, exp_od;
  logic [63:0] act_v, exp_v;

  initial begin
    drive(1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0);

    //           rst   fl    iv    data           ordy  eov   eod            chkd  eir   eocc
    // Reset held two cycles with traffic offered, then a single push.
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, RV,           1'b1, 1'b1, 2'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, RV,           1'b1, 1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 32'h1,        1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0));
    // Backpressure: fill to FULL, 0xC offered while full is ignored.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hA,         1'b0, 1'b1, 32'hA,        1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hB,         1'b0, 1'b1, 32'hA,        1'b1, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hC,         1'b0, 1'b1, 32'hA,        1'b1, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hB,        1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 2'd0));
    // Simultaneous push and pop while ONE.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h5,         1'b0, 1'b1, 32'h5,        1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h6,         1'b1, 1'b1, 32'h6,        1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h6,        1'b1, 1'b1, 2'd1));
    // Flush while FULL with 0x7 offered; 0x7 must be lost.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h8,         1'b0, 1'b1, 32'h6,        1'b1, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h7,         1'b0, 1'b0, RV,           1'b1, 1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, RV,           1'b1, 1'b1, 2'd0));
    // Payload held under stall, then reset overrides a FULL stage.
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h21,        1'b0, 1'b1, 32'h21,       1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h22,        1'b0, 1'b1, 32'h21,       1'b1, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h99,        1'b0, 1'b1, 32'h21,       1'b1, 1'b0, 2'd2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h23,        1'b1, 1'b0, RV,           1'b1, 1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, RV,           1'b1, 1'b1, 2'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].eov});
      chk($sformatf("v%0d in_ready", i),  {63'd0, in_ready},  {63'd0, vecs[i].eir});
      chk($sformatf("v%0d occ", i),       {62'd0, occ},       {62'd0, vecs[i].eocc});
      if (vecs[i].chkd)
        chk($sformatf("v%0d out_data", i), {32'd0, out_data}, {32'd0, vecs[i].eod});
    end

    // Streaming: 0x10..0x1F on consecutive cycles with out_ready high.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h10 + 32'(i), 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d", i), {28'd0, out_valid, in_ready, occ, out_data},
          {28'd0, 1'b1, 1'b1, 2'd1, 32'h10 + 32'(i)});
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("stream_drain", {62'd0, occ}, 64'd0);

    // Random traffic against a queue model of the stage.
    for (int c = 0; c < 10000; c++) begin
      r_iv = 1'($urandom_range(0, 1));
      r_or = 1'($urandom_range(0, 1));
      r_d  = $urandom;
      drive(1'b0, 1'b0, r_iv, r_d, r_or);
      m_fi = r_iv && (model_q.size() < 2);
      m_fo = r_or && (model_q.size() > 0);
      if (m_fo) void'(model_q.pop_front());
      if (m_fi) model_q.push_back(r_d);
      @(posedge clk);
      #1;
      exp_od = (model_q.size() > 0) ? model_q[0] : 32'h0;
      act_v  = {28'd0, out_valid, in_ready, occ, (out_valid ? out_data : 32'h0)};
      exp_v  = {28'd0, (model_q.size() > 0), (model_q.size() < 2),
                2'(model_q.size()), exp_od};
      chk($sformatf("rand%0d", c), act_v, exp_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
